imm_ext_stage: RTL and testbench

Registered, parametrised immediate-extension stage for the Decode pipeline. It takes a raw instruction immediate with a mode select and produces an OUT_W-bit operand one cycle later. Supported modes are sign-extend, zero-extend, LUI upper-placement and branch-offset (sign-extend then shift left 2). It sits between instruction decode and the ID/EX register, uses a valid/ready handshake with a 2-entry skid buffer, and supports a pipeline flush.

---
 rtl/imm_ext_stage.sv | 207 ++++++++++++++++++++
 tb/tb_imm_ext_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: one-cycle registered immediate extension (SEXT/ZEXT/LUI/BR) with valid/ready.
// Optional macro IMM_EXT_SKID_EN adds a skid register and makes in_ready a registered output.
module imm_ext_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        MODE_SEXT = 2'd0,
        MODE_ZEXT = 2'd1,
        MODE_LUI  = 2'd2,
        MODE_BR   = 2'd3
    } mode_e;

    // Built by overlaying slices so IN_W == OUT_W never needs a zero-width replication.
    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      mode);
        logic [OUT_W-1:0] sext;
        logic [OUT_W-1:0] zext;
        logic [OUT_W-1:0] lui;
        logic [OUT_W-1:0] res;
        zext                 = '0;
        zext[IN_W-1:0]       = imm;
        sext                 = {OUT_W{imm[IN_W-1]}};
        sext[IN_W-1:0]       = imm;
        lui                  = '0;
        lui[OUT_W-1 -: IN_W] = imm;
        case (mode_e'(mode))
            MODE_SEXT: res = sext;
            MODE_ZEXT: res = zext;
            MODE_LUI:  res = lui;
            MODE_BR:   res = sext << 2;
            default:   res = sext;
        endcase
        return res;
    endfunction

    logic [OUT_W-1:0] ext_data;
    logic             accept;
    logic             drain;
    logic [OUT_W-1:0] oreg_data_q;
    logic [OUT_W-1:0] oreg_data_d;
    logic [TAG_W-1:0] oreg_tag_q;
    logic [TAG_W-1:0] oreg_tag_d;

    always_comb begin
        ext_data = extend(in_imm, in_mode);
        // rst is already folded into in_ready; flush only cancels the input side
        accept   = in_valid & in_ready & ~flush;
        drain    = out_valid & out_ready;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            oreg_data_q <= '0;
            oreg_tag_q  <= '0;
        end else begin
            oreg_data_q <= oreg_data_d;
            oreg_tag_q  <= oreg_tag_d;
        end
    end

    assign out_data = oreg_data_q;
    assign out_tag  = oreg_tag_q;

`ifdef IMM_EXT_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic [OUT_W-1:0] skid_data_q;
    logic [OUT_W-1:0] skid_data_d;
    logic [TAG_W-1:0] skid_tag_q;
    logic [TAG_W-1:0] skid_tag_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // NOTE: skid payload has no reset; it is only read when the state says SKID is occupied.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
        skid_tag_q  <= skid_tag_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = ONE;
            ONE: begin
                if (accept && !drain)      state_d = FULL;
                else if (!accept && drain) state_d = EMPTY;
            end
            FULL:    if (drain) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
        in_ready_d = (state_d != FULL);
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        oreg_data_d = oreg_data_q;
        oreg_tag_d  = oreg_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        // Gated by flush so out_data keeps its last value after the flush empties the stage.
        if (!flush) begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        oreg_data_d = ext_data;
                        oreg_tag_d  = in_tag;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        oreg_data_d = ext_data;
                        oreg_tag_d  = in_tag;
                    end else if (accept) begin
                        skid_data_d = ext_data;
                        skid_tag_d  = in_tag;
                    end
                end
                FULL: begin
                    if (drain) begin
                        oreg_data_d = skid_data_q;
                        oreg_tag_d  = skid_tag_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = in_ready_q & ~rst;
    end

`else

    typedef enum logic {
        EMPTY = 1'b0,
        ONE   = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept)     state_d = ONE;
        else if (drain) state_d = EMPTY;
        if (flush)      state_d = EMPTY;
    end

    always_comb begin
        oreg_data_d = oreg_data_q;
        oreg_tag_d  = oreg_tag_q;
        if (accept) begin
            oreg_data_d = ext_data;
            oreg_tag_d  = in_tag;
        end
    end

    always_comb begin
        out_valid = (state_q == ONE);
        in_ready  = ~rst & (~out_valid | out_ready);
    end

`endif

endmodule

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench for imm_ext_stage: queue-based reference model plus directed literal checks.
// Adapts its capacity/in_ready expectations to whether IMM_EXT_SKID_EN is defined.
`timescale 1ns/1ps
module tb_imm_ext_stage;

`ifdef IMM_EXT_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
    } ent_t;

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [4:0]  tag;
    } stim_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    logic        b_rst;
    logic        b_flush;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [11:0] b_in_imm;
    logic [1:0]  b_in_mode;
    logic [4:0]  b_in_tag;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [15:0] b_out_data;
    logic [4:0]  b_out_tag;

    int n_pass  = 0;
    int n_total = 0;

    ent_t        q[$];
    logic [31:0] shown_data;
    logic [4:0]  shown_tag;
    bit          live = 1'b0;
    logic [4:0]  rx[$];
    stim_t       pending[$];

    imm_ext_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_imm   (in_imm),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag)
    );

    imm_ext_stage #(.IN_W(12), .OUT_W(16), .TAG_W(5)) dut_b (
        .clk      (clk),
        .rst      (b_rst),
        .flush    (b_flush),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_imm   (b_in_imm),
        .in_mode  (b_in_mode),
        .in_tag   (b_in_tag),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_data (b_out_data),
        .out_tag  (b_out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Arithmetic reference for the four extension modes.
    function automatic logic [31:0] ref_ext(input int in_w, input int out_w,
                                            input logic [31:0] imm, input logic [1:0] mode);
        longint m;
        longint s;
        m = (longint'(1) << out_w) - 1;
        s = longint'(imm);
        if (imm[in_w-1]) s = s - (longint'(1) << in_w);
        case (mode)
            2'd0:    return 32'(s & m);
            2'd1:    return 32'(longint'(imm) & m);
            2'd2:    return 32'((longint'(imm) << (out_w - in_w)) & m);
            default: return 32'((s * 4) & m);
        endcase
    endfunction

    function automatic logic model_in_ready();
        if (rst) return 1'b0;
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    // Reference model: a FIFO of capacity 2 (skid) or 1 (no skid).
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            live <= 1'b1;
        end else if (!flush) begin
            case ({in_valid && model_in_ready(), (q.size() > 0) && out_ready})
                2'b10: q.push_back('{ref_ext(16, 32, 32'(in_imm), in_mode), in_tag});
                2'b01: void'(q.pop_front());
                2'b11: begin
                    void'(q.pop_front());
                    q.push_back('{ref_ext(16, 32, 32'(in_imm), in_mode), in_tag});
                end
                default: ;
            endcase
        end else begin
            q.delete();
        end
        if (rst) begin
            shown_data <= '0;
            shown_tag  <= '0;
        end else if (q.size() > 0) begin
            shown_data <= q[0].data;
            shown_tag  <= q[0].tag;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("model_out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("model_out_data", 64'(out_data), 64'(shown_data));
            check("model_out_tag", 64'(out_tag), 64'(shown_tag));
            check("model_in_ready", 64'(in_ready), 64'(model_in_ready()));
            if (out_valid && out_ready && !rst) rx.push_back(out_tag);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents pending[0] for one cycle and pops it if the handshake completes.
    task automatic cycle_push();
        bit acc;
        if (pending.size() > 0) begin
            in_valid = 1'b1;
            in_imm   = pending[0].imm;
            in_mode  = pending[0].mode;
            in_tag   = pending[0].tag;
        end else begin
            in_valid = 1'b0;
        end
        @(negedge clk);
        acc = in_valid && in_ready && !flush && !rst;
        step();
        if (acc) void'(pending.pop_front());
    endtask

    task automatic send_check(input logic [15:0] imm, input logic [1:0] mode,
                              input logic [4:0] tag, input logic [31:0] exp, input string name);
        step();
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'(1));
        check({name, "_data"}, 64'(out_data), 64'(exp));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
    endtask

    task automatic b_send_check(input logic [11:0] imm, input logic [1:0] mode,
                                input logic [15:0] exp, input string name);
        step();
        b_in_valid = 1'b1;
        b_in_imm   = imm;
        b_in_mode  = mode;
        b_in_tag   = 5'd3;
        step();
        b_in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 64'(b_out_valid), 64'(1));
        check({name, "_data"}, 64'(b_out_data), 64'(exp));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0;
        out_ready = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_imm = '0; b_in_mode = '0;
        b_in_tag = '0; b_out_ready = 1'b1;

        step();
        @(negedge clk);
        check("reset_in_ready_low", 64'(in_ready), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_data", 64'(out_data), 64'(0));
        step();
        rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(in_ready), 64'(1));
        check("b_ready_after_rst", 64'(b_in_ready), 64'(1));

        out_ready = 1'b1;
        send_check(16'h1234, 2'd0, 5'd10, 32'h0000_1234, "sext_pos");
        send_check(16'hF234, 2'd0, 5'd11, 32'hFFFF_F234, "sext_neg");
        send_check(16'hF234, 2'd1, 5'd12, 32'h0000_F234, "zext");
        send_check(16'h1234, 2'd2, 5'd13, 32'h1234_0000, "lui");
        send_check(16'hFFF8, 2'd3, 5'd14, 32'hFFFF_FFE0, "br");

        // Backpressure: out_ready low while tags 1..4 stream in.
        step();
        out_ready = 1'b0;
        rx.delete();
        for (int i = 1; i <= 4; i++)
            pending.push_back('{16'($urandom), 2'($urandom), 5'(i)});
        repeat (2) cycle_push();
        check("bp_accepted", 64'(4 - pending.size()), 64'(SKID ? 2 : 1));
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 20 && pending.size() > 0; k++) cycle_push();
        in_valid = 1'b0;
        check("bp_all_sent", 64'(pending.size()), 64'(0));
        repeat (4) step();
        check("bp_rx_count", 64'(rx.size()), 64'(4));
        for (int i = 0; i < 4 && i < rx.size(); i++)
            check("bp_rx_order", 64'(rx[i]), 64'(i + 1));

        // Flush while full, with a competing input tagged 7.
        out_ready = 1'b0;
        rx.delete();
        pending.delete();
        pending.push_back('{16'h0005, 2'd0, 5'd5});
        pending.push_back('{16'h0006, 2'd1, 5'd6});
        repeat (2) cycle_push();
        in_valid = 1'b1;
        in_imm   = 16'h0007;
        in_mode  = 2'd0;
        in_tag   = 5'd7;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready", 64'(in_ready), 64'(1));
        check("flush_data_held", 64'(out_tag), 64'(5));
        pending.delete();
        out_ready = 1'b1;
        repeat (4) step();
        check("flush_no_output", 64'(rx.size()), 64'(0));

        // Reset with entries held.
        out_ready = 1'b0;
        pending.push_back('{16'h0008, 2'd0, 5'd8});
        pending.push_back('{16'h0009, 2'd0, 5'd9});
        repeat (2) cycle_push();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_tag   = 5'd10;
        @(negedge clk);
        check("rst_in_ready_low", 64'(in_ready), 64'(0));
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        pending.delete();
        rx.delete();
        out_ready = 1'b1;
        repeat (3) step();
        check("rst_no_output", 64'(rx.size()), 64'(0));

        // Randomized traffic; the model compare process checks every cycle.
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 150) == 0);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        // Narrow parameter set.
        b_send_check(12'h800, 2'd0, 16'hF800, "b_sext");
        b_send_check(12'h800, 2'd2, 16'h8000, "b_lui");
        b_send_check(12'h7FF, 2'd3, 16'h1FFC, "b_br");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
